// File: rtl/lc3_ctrl_pkg.sv
// lc3_ctrl_pkg: state codes, opcodes, select encodings and the control-word layout
package lc3_ctrl_pkg;
  typedef enum logic [4:0] {
    S_F0 = 5'd0, S_F1, S_F2, S_DEC, S_ALU, S_BR, S_JMP, S_JSR1, S_JSR2, S_ADR, S_LEA,
    S_M1, S_IND, S_MEM, S_WB, S_ST, S_WR, S_T1, S_T2, S_T3, S_HALT
  } state_t;
  localparam logic [3:0] OP_BR = 4'h0, OP_ADD = 4'h1, OP_LD = 4'h2, OP_ST = 4'h3;
  localparam logic [3:0] OP_JSR = 4'h4, OP_AND = 4'h5, OP_LDR = 4'h6, OP_STR = 4'h7;
  localparam logic [3:0] OP_RTI = 4'h8, OP_NOT = 4'h9, OP_LDI = 4'hA, OP_STI = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC, OP_RES = 4'hD, OP_LEA = 4'hE, OP_TRAP = 4'hF;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_AND = 2'b01, ALU_NOT = 2'b10, ALU_PASS = 2'b11;
  localparam logic [1:0] PC_INC = 2'b00, PC_EAB = 2'b01, PC_BUS = 2'b10;
  localparam logic [1:0] EAB2_ZERO = 2'b00, EAB2_OFF6 = 2'b01, EAB2_OFF9 = 2'b10, EAB2_OFF11 = 2'b11;
  localparam logic MAR_ZEXT = 1'b0, MAR_EAB = 1'b1;
  // Field order matches the top-level output port order so it can be unpacked in one assign
  typedef struct packed {
    logic [1:0] alu;
    logic       ena_alu, ena_marm, ena_mdr, ena_pc, sel_mar, sel_eab1;
    logic [1:0] sel_eab2, sel_pc;
    logic       sel_mdr, ld_pc, ld_ir, ld_mar, ld_mdr, ld_cc, reg_we, mem_we, halted;
  } ctrl_t;
endpackage

// File: rtl/lc3_ctrl_decode.sv
// lc3_ctrl_decode: Moore output decode from current state, IR and the latched branch decision
module lc3_ctrl_decode import lc3_ctrl_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter logic [7:0] HALT_VECT = 8'h25
) (
  input  state_t              state,
  input  logic [DATA_W-1:0]   ir,
  input  logic                ben,
  output ctrl_t               ctrl,
  output logic [REG_AW-1:0]   sr1,
  output logic [REG_AW-1:0]   sr2,
  output logic [REG_AW-1:0]   dr,
  output logic                halt_vec
);
  logic [3:0] op;
  logic       rel;
  assign op = ir[DATA_W-1 -: 4];
  assign rel = op == OP_LDR || op == OP_STR;
  assign halt_vec = ir[7:0] == HALT_VECT;
  always_comb begin
    ctrl = '0;
    sr1 = '0;
    sr2 = '0;
    dr = '0;
    case (state)
      S_F0: begin ctrl.ena_pc = 1'b1; ctrl.ld_mar = 1'b1; ctrl.ld_pc = 1'b1; ctrl.sel_pc = PC_INC; end
      S_F1, S_M1, S_MEM: begin ctrl.sel_mdr = 1'b1; ctrl.ld_mdr = 1'b1; end
      S_F2: begin ctrl.ena_mdr = 1'b1; ctrl.ld_ir = 1'b1; end
      S_ALU: begin
        ctrl.alu = op == OP_ADD ? ALU_ADD : op == OP_AND ? ALU_AND : ALU_NOT;
        ctrl.ena_alu = 1'b1; ctrl.reg_we = 1'b1; ctrl.ld_cc = 1'b1;
        dr = REG_AW'(ir[11:9]); sr1 = REG_AW'(ir[8:6]); sr2 = REG_AW'(ir[2:0]);
      end
      S_BR: begin ctrl.sel_eab2 = EAB2_OFF9; ctrl.sel_pc = PC_EAB; ctrl.ld_pc = ben; end
      S_JMP: begin
        ctrl.sel_eab1 = 1'b1; ctrl.sel_eab2 = EAB2_ZERO; ctrl.sel_pc = PC_EAB; ctrl.ld_pc = 1'b1;
        sr1 = REG_AW'(ir[8:6]);
      end
      S_JSR1, S_T1: begin ctrl.ena_pc = 1'b1; ctrl.reg_we = 1'b1; dr = REG_AW'(3'd7); end
      // IR[11] selects PC-relative JSR over register-based JSRR
      S_JSR2: begin
        ctrl.ld_pc = 1'b1; ctrl.sel_pc = PC_EAB;
        ctrl.sel_eab1 = !ir[11]; ctrl.sel_eab2 = ir[11] ? EAB2_OFF11 : EAB2_ZERO;
        sr1 = ir[11] ? '0 : REG_AW'(ir[8:6]);
      end
      S_ADR: begin
        ctrl.sel_mar = MAR_EAB; ctrl.ld_mar = 1'b1;
        ctrl.sel_eab1 = rel; ctrl.sel_eab2 = rel ? EAB2_OFF6 : EAB2_OFF9;
        sr1 = rel ? REG_AW'(ir[8:6]) : '0;
      end
      S_LEA: begin
        ctrl.ena_marm = 1'b1; ctrl.sel_mar = MAR_EAB; ctrl.sel_eab2 = EAB2_OFF9;
        ctrl.reg_we = 1'b1; ctrl.ld_cc = 1'b1; dr = REG_AW'(ir[11:9]);
      end
      S_IND: begin ctrl.ena_mdr = 1'b1; ctrl.ld_mar = 1'b1; end
      S_WB: begin ctrl.ena_mdr = 1'b1; ctrl.reg_we = 1'b1; ctrl.ld_cc = 1'b1; dr = REG_AW'(ir[11:9]); end
      S_ST: begin
        ctrl.ena_alu = 1'b1; ctrl.alu = ALU_PASS; ctrl.ld_mdr = 1'b1; sr1 = REG_AW'(ir[11:9]);
      end
      S_WR: ctrl.mem_we = 1'b1;
      S_T2: begin ctrl.sel_mar = MAR_ZEXT; ctrl.ena_marm = 1'b1; ctrl.ld_mar = 1'b1; end
      S_T3: begin ctrl.ena_mdr = 1'b1; ctrl.sel_pc = PC_BUS; ctrl.ld_pc = 1'b1; end
      S_HALT: ctrl.halted = 1'b1;
      default: ;
    endcase
  end
endmodule

// File: rtl/lc3_control_fsm.sv
// lc3_control_fsm: multi-cycle LC-3 sequencer; state register, next-state logic and reset-gated outputs
module lc3_control_fsm import lc3_ctrl_pkg::*; #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter logic [7:0] HALT_VECT = 8'h25
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] IR,
  input  logic              N,
  input  logic              Z,
  input  logic              P,
  input  logic              mem_ready,
  output logic [1:0]        aluControl,
  output logic              enaALU,
  output logic              enaMARM,
  output logic              enaMDR,
  output logic              enaPC,
  output logic              selMAR,
  output logic              selEAB1,
  output logic [1:0]        selEAB2,
  output logic [1:0]        selPC,
  output logic              selMDR,
  output logic              ldPC,
  output logic              ldIR,
  output logic              ldMAR,
  output logic              ldMDR,
  output logic              ldCC,
  output logic [REG_AW-1:0] SR1,
  output logic [REG_AW-1:0] SR2,
  output logic [REG_AW-1:0] DR,
  output logic              regWE,
  output logic              memWE,
  output logic              halted,
  output logic [4:0]        state_dbg
);
  state_t            state_q, state_d;
  logic              ben_q, ben_d, go, halt_vec;
  logic [3:0]        op;
  ctrl_t             dec, c;
  logic [REG_AW-1:0] sr1, sr2, dr;
  assign op = IR[DATA_W-1 -: 4];
  assign go = !MEM_HANDSHAKE || mem_ready;
  lc3_ctrl_decode #(.DATA_W(DATA_W), .REG_AW(REG_AW), .HALT_VECT(HALT_VECT)) u_dec (
    .state(state_q), .ir(IR), .ben(ben_q), .ctrl(dec), .sr1(sr1), .sr2(sr2), .dr(dr), .halt_vec(halt_vec)
  );
  // Branch condition is captured in DEC so NZP never reaches the outputs combinationally
  always_comb begin
    ben_d = state_q == S_DEC ? (IR[11] & N) | (IR[10] & Z) | (IR[9] & P) : ben_q;
    state_d = S_F0;
    case (state_q)
      S_F0: state_d = S_F1;
      S_F1: state_d = go ? S_F2 : S_F1;
      S_F2: state_d = S_DEC;
      S_DEC:
        case (op)
          OP_BR: state_d = S_BR;
          OP_ADD, OP_AND, OP_NOT: state_d = S_ALU;
          OP_LD, OP_LDR, OP_LDI, OP_ST, OP_STR, OP_STI: state_d = S_ADR;
          OP_LEA: state_d = S_LEA;
          OP_JSR: state_d = S_JSR1;
          OP_JMP: state_d = S_JMP;
          OP_TRAP: state_d = S_T1;
          default: state_d = S_HALT;
        endcase
      S_JSR1: state_d = S_JSR2;
      S_ADR: state_d = op == OP_LDI || op == OP_STI ? S_M1 : op == OP_ST || op == OP_STR ? S_ST : S_MEM;
      S_M1: state_d = go ? S_IND : S_M1;
      S_IND: state_d = op == OP_STI ? S_ST : S_MEM;
      S_MEM: state_d = go ? (op == OP_TRAP ? S_T3 : S_WB) : S_MEM;
      S_ST: state_d = S_WR;
      S_WR: state_d = go ? S_F0 : S_WR;
      S_T1: state_d = halt_vec ? S_HALT : S_T2;
      S_T2: state_d = S_MEM;
      S_HALT: state_d = S_HALT;
      default: state_d = S_F0;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_F0;
      ben_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ben_q <= ben_d;
    end
  end
  assign c = reset ? dec : '0;
  assign {aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2, selPC,
          selMDR, ldPC, ldIR, ldMAR, ldMDR, ldCC, regWE, memWE, halted} = c;
  assign SR1 = reset ? sr1 : '0;
  assign SR2 = reset ? sr2 : '0;
  assign DR = reset ? dr : '0;
  assign state_dbg = state_q;
endmodule

// File: tb/tb_lc3_control_fsm.sv
// tb_lc3_control_fsm: per-instruction latency/strobe model with a wait-state memory responder
module tb_lc3_control_fsm;
  import lc3_ctrl_pkg::*;
  logic clk = 1'b0, reset = 1'b1;
  logic [15:0] IR = '0;
  logic N = 1'b0, Z = 1'b0, P = 1'b0, mem_ready = 1'b0;
  logic [1:0] aluControl, selEAB2, selPC;
  logic enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selMDR;
  logic ldPC, ldIR, ldMAR, ldMDR, ldCC, regWE, memWE, halted;
  logic [2:0] SR1, SR2, DR;
  logic [4:0] state_dbg;
  logic [29:0] outs;
  logic noise = 1'b1;
  int compared = 0, mismatched = 0;

  lc3_control_fsm dut (
    .clk(clk), .reset(reset), .IR(IR), .N(N), .Z(Z), .P(P), .mem_ready(mem_ready),
    .aluControl(aluControl), .enaALU(enaALU), .enaMARM(enaMARM), .enaMDR(enaMDR), .enaPC(enaPC),
    .selMAR(selMAR), .selEAB1(selEAB1), .selEAB2(selEAB2), .selPC(selPC), .selMDR(selMDR),
    .ldPC(ldPC), .ldIR(ldIR), .ldMAR(ldMAR), .ldMDR(ldMDR), .ldCC(ldCC),
    .SR1(SR1), .SR2(SR2), .DR(DR), .regWE(regWE), .memWE(memWE), .halted(halted), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;
  assign outs = {aluControl, enaALU, enaMARM, enaMDR, enaPC, selMAR, selEAB1, selEAB2, selPC, selMDR,
                 ldPC, ldIR, ldMAR, ldMDR, ldCC, SR1, SR2, DR, regWE, memWE, halted};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory accesses per instruction (fetch included) and cycles spent outside memory accesses
  function automatic int n_acc(input logic [3:0] op);
    case (op)
      OP_LD, OP_LDR, OP_ST, OP_STR, OP_TRAP: return 2;
      OP_LDI, OP_STI: return 3;
      default: return 1;
    endcase
  endfunction
  function automatic int n_fixed(input logic [3:0] op);
    case (op)
      OP_JSR, OP_LD, OP_LDR, OP_ST, OP_STR: return 5;
      OP_LDI, OP_STI, OP_TRAP: return 6;
      default: return 4;
    endcase
  endfunction

  task automatic run_instr(input logic [15:0] ir, input logic [2:0] nzp, input int wlo, input int whi);
    int w[$];
    int acc_exp, exp_cyc, exp_rd, exp_mw, exp_we, exp_cc, exp_pc, cyc, nacc, cur, rd, mw, we, cc, pc, bad, last;
    logic [2:0] dr_obs, exp_dr;
    logic [7:0] pcw, pcw_exp, alw, alw_exp;
    logic [5:0] adw, adw_exp;
    logic acc, in_acc, taken, has_alu, has_adr, store;
    logic [3:0] op;
    op = ir[15:12];
    IR = ir;
    {N, Z, P} = nzp;
    acc_exp = n_acc(op);
    exp_cyc = n_fixed(op);
    exp_rd = 0;
    last = 0;
    for (int i = 0; i < acc_exp; i++) begin
      last = $urandom_range(whi, wlo);
      w.push_back(last);
      exp_cyc += last + 1;
      exp_rd += last + 1;
    end
    store = op == OP_ST || op == OP_STR || op == OP_STI;
    exp_mw = store ? last + 1 : 0;
    exp_rd -= exp_mw;
    taken = (ir[11] & nzp[2]) | (ir[10] & nzp[1]) | (ir[9] & nzp[0]);
    exp_we = 0; exp_cc = 0; exp_dr = ir[11:9]; exp_pc = 0; pcw_exp = '0;
    has_alu = 1'b0; has_adr = 1'b0; alw_exp = '0;
    case (op)
      OP_ADD, OP_AND, OP_NOT: begin
        exp_we = 1; exp_cc = 1; has_alu = 1'b1;
        alw_exp = {op == OP_ADD ? 2'b00 : op == OP_AND ? 2'b01 : 2'b10, ir[8:6], ir[2:0]};
      end
      OP_LD, OP_LDR, OP_LDI: begin exp_we = 1; exp_cc = 1; has_adr = 1'b1; end
      OP_LEA: begin exp_we = 1; exp_cc = 1; end
      OP_ST, OP_STR, OP_STI: begin has_adr = 1'b1; has_alu = 1'b1; alw_exp = {2'b11, ir[11:9], 3'b000}; end
      OP_BR: begin exp_pc = int'(taken); pcw_exp = {2'b01, 1'b0, 2'b10, 3'b000}; end
      OP_JMP: begin exp_pc = 1; pcw_exp = {2'b01, 1'b1, 2'b00, ir[8:6]}; end
      OP_JSR: begin
        exp_we = 1; exp_dr = 3'd7; exp_pc = 1;
        pcw_exp = ir[11] ? {2'b01, 1'b0, 2'b11, 3'b000} : {2'b01, 1'b1, 2'b00, ir[8:6]};
      end
      OP_TRAP: begin exp_we = 1; exp_dr = 3'd7; exp_pc = 1; pcw_exp = {2'b10, 6'b0}; end
      default: ;
    endcase
    adw_exp = (op == OP_LDR || op == OP_STR) ? {1'b1, 2'b01, ir[8:6]} : {1'b0, 2'b10, 3'b000};
    check("start_state", {27'd0, state_dbg}, {27'd0, S_F0});
    nacc = 0; cur = 0; rd = 0; mw = 0; we = 0; cc = 0; pc = 0; bad = 0; in_acc = 1'b0;
    dr_obs = '0; pcw = '0; alw = '0; adw = '0;
    for (cyc = 0; cyc < 100; ) begin
      acc = (ldMDR && selMDR) || memWE;
      rd += int'(ldMDR && selMDR);
      mw += int'(memWE);
      cc += int'(ldCC);
      if (regWE) begin we++; dr_obs = DR; end
      bad += int'(($countones({enaALU, enaMARM, enaMDR, enaPC}) > 1) || (ldCC && !regWE) || halted);
      if (ldPC && cyc > 0) begin pc++; pcw = {selPC, selEAB1, selEAB2, SR1}; end
      if (enaALU) alw = {aluControl, SR1, SR2};
      if (ldMAR && selMAR) adw = {selEAB1, selEAB2, SR1};
      if (acc && !in_acc) begin nacc++; cur = w.size() > 0 ? w.pop_front() : 0; end
      in_acc = acc;
      mem_ready = acc ? (cur == 0) : (noise ? 1'($urandom) : 1'b1);
      if (acc && cur > 0) cur--;
      cyc++;
      @(negedge clk);
      if (enaPC && ldMAR && ldPC) break;
    end
    check("cycles", cyc, exp_cyc);
    check("accesses", nacc, acc_exp);
    check("read_cycles", rd, exp_rd);
    check("write_cycles", mw, exp_mw);
    check("reg_writes", we, exp_we);
    if (exp_we > 0) check("dest_reg", {29'd0, dr_obs}, {29'd0, exp_dr});
    check("cc_loads", cc, exp_cc);
    check("pc_loads", pc, exp_pc);
    if (exp_pc > 0) check("pc_select", {24'd0, pcw}, {24'd0, pcw_exp});
    if (has_alu) check("alu_word", {24'd0, alw}, {24'd0, alw_exp});
    if (has_adr) check("addr_word", {26'd0, adw}, {26'd0, adw_exp});
    check("invariants", bad, 0);
  endtask

  task automatic run_halt(input logic [15:0] ir, input int exp_len, input int exp_r7);
    int cyc, we, ccn, bad;
    logic [2:0] dr_obs;
    cyc = 0; we = 0; ccn = 0; bad = 0; dr_obs = '0;
    IR = ir;
    mem_ready = 1'b1;
    while (!halted && cyc < 50) begin
      if (regWE) begin we++; dr_obs = DR; end
      ccn += int'(ldCC);
      cyc++;
      @(negedge clk);
    end
    check("halt_entry", cyc, exp_len);
    check("halt_writes", we, exp_r7);
    if (exp_r7 > 0) check("halt_r7", {29'd0, dr_obs}, 32'd7);
    check("halt_cc", ccn, 0);
    for (int i = 0; i < 100; i++) begin
      {IR, N, Z, P, mem_ready} = 20'($urandom);
      @(negedge clk);
      bad += int'(outs !== 30'd1 || state_dbg !== S_HALT);
    end
    check("halt_hold", bad, 0);
    reset = 1'b0;
    @(negedge clk);
    check("halt_reset", {27'd0, state_dbg}, {27'd0, S_F0});
    reset = 1'b1;
  endtask

  initial begin
    logic seen;
    logic [15:0] r;
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outs", {2'd0, outs}, 32'd0);
    check("reset_state", {27'd0, state_dbg}, {27'd0, S_F0});
    reset = 1'b1;
    noise = 1'b0;
    run_instr(16'h1283, 3'b000, 0, 0);
    noise = 1'b1;
    run_instr(16'h0405, 3'b010, 0, 1);
    run_instr(16'h0405, 3'b100, 0, 1);
    run_instr(16'h0005, 3'b111, 0, 1);
    run_instr(16'h6545, 3'b000, 3, 3);
    run_instr(16'hB602, 3'b001, 1, 2);
    run_instr(16'hE3FF, 3'b000, 0, 2);
    run_instr(16'h4801, 3'b000, 0, 2);
    run_instr(16'h4080, 3'b000, 0, 2);
    run_instr(16'hC1C0, 3'b000, 0, 2);
    run_instr(16'hF023, 3'b000, 0, 2);
    repeat (150) begin
      do r = 16'($urandom);
      while (r[15:12] == OP_RTI || r[15:12] == OP_RES || (r[15:12] == OP_TRAP && r[7:0] == 8'h25));
      run_instr(r, 3'($urandom), 0, 3);
    end
    IR = 16'h3A10;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      mem_ready = 1'b1;
      @(negedge clk);
      seen = memWE;
    end
    check("wr_reached", {31'd0, seen}, 32'd1);
    mem_ready = 1'b0;
    @(negedge clk);
    check("wr_held", {31'd0, memWE}, 32'd1);
    #2 reset = 1'b0;
    #1 check("midwr_outs", {2'd0, outs}, 32'd0);
    check("midwr_state", {27'd0, state_dbg}, {27'd0, S_F0});
    @(negedge clk);
    reset = 1'b1;
    run_instr(16'h1283, 3'b000, 0, 2);
    run_halt(16'hF025, 5, 1);
    run_halt(16'hD000, 4, 0);
    run_halt(16'h8000, 4, 0);
    run_instr(16'h5A3F, 3'b000, 0, 2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
